// File: rtl/pwr_fault_logger_if.sv
// Log drain channel between the fault logger (master) and the BMC-facing reader (slave).
// LOG_W must match the logger's entry width (NUM_FLT+4, or NUM_FLT+20 with timestamps).
interface pwr_fault_logger_if #(
    parameter int LOG_W = 11
) ();
    logic             oLog_Valid;
    logic [LOG_W-1:0] oLog_Data;
    logic             iLog_Pop;

    modport master (
        output oLog_Valid,
        output oLog_Data,
        input  iLog_Pop
    );

    modport slave (
        input  oLog_Valid,
        input  oLog_Data,
        output iLog_Pop
    );
endinterface

// File: rtl/pwr_fault_logger.sv
// Power-fault logger: edge-detects active-low fault flags, latches the first fault and queues events in a FIFO.
// Optional FAULT_LOG_TIMESTAMP_EN adds a saturating 16-bit ms timestamp to every entry.
module pwr_fault_logger #(
    parameter int DEPTH   = 4,
    parameter int NUM_FLT = 7
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iTick_1ms,
    input  logic [NUM_FLT-1:0] iFlt_N,
    input  logic [3:0]         iSeq_State,
    input  logic               iClear,
    pwr_fault_logger_if.master log_if,
    output logic               oFault_Any,
    output logic [3:0]         oFirst_Code,
    output logic [3:0]         oFirst_State,
    output logic               oOverflow,
    output logic [4:0]         oCount
);
`ifdef FAULT_LOG_TIMESTAMP_EN
    localparam int LOG_W = NUM_FLT + 20;
`else
    localparam int LOG_W = NUM_FLT + 4;
`endif
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [4:0] CNT_FULL = 5'(DEPTH);
    localparam logic [3:0] NO_FAULT = 4'hF;

    typedef logic [LOG_W-1:0] entry_t;

    function automatic logic [3:0] lowest_idx(input logic [NUM_FLT-1:0] m);
        logic [3:0] idx;
        idx = NO_FAULT;
        for (int i = NUM_FLT - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_FLT-1:0] prev_n_q, prev_n_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic               fault_any_q, fault_any_d;
    logic [3:0]         first_code_q, first_code_d;
    logic [3:0]         first_state_q, first_state_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        ts_q, ts_d;

    logic [NUM_FLT-1:0] new_flt;
    logic               push, pop, full, wr_en;
    entry_t             entry;

    always_comb begin
        new_flt = prev_n_q & ~iFlt_N;
        push    = (|new_flt) && !iClear;
        pop     = log_if.iLog_Pop && (count_q != 5'd0) && !iClear;
        full    = (count_q == CNT_FULL);
        // A pop on a full FIFO frees the slot the same-cycle push lands in.
        wr_en   = push && (!full || pop);
`ifdef FAULT_LOG_TIMESTAMP_EN
        entry   = {ts_q, iSeq_State, new_flt};
`else
        entry   = {iSeq_State, new_flt};
`endif
    end

    always_comb begin
        prev_n_d      = iFlt_N;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fault_any_d   = fault_any_q;
        first_code_d  = first_code_q;
        first_state_d = first_state_q;
        overflow_d    = overflow_q;
        ts_d          = ts_q;

        if (iClear) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = 5'd0;
            fault_any_d   = 1'b0;
            first_code_d  = NO_FAULT;
            first_state_d = 4'h0;
            overflow_d    = 1'b0;
            ts_d          = 16'd0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {4'd0, wr_en} - {4'd0, pop};
            if (push && !wr_en) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                fault_any_d = 1'b1;
                if (first_code_q == NO_FAULT) begin
                    first_code_d  = lowest_idx(new_flt);
                    first_state_d = iSeq_State;
                end
            end
`ifdef FAULT_LOG_TIMESTAMP_EN
            if (iTick_1ms) begin
                ts_d = sat_inc16(ts_q);
            end
`endif
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prev_n_q      <= '1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 5'd0;
            fault_any_q   <= 1'b0;
            first_code_q  <= NO_FAULT;
            first_state_q <= 4'h0;
            overflow_q    <= 1'b0;
            ts_q          <= 16'd0;
        end else begin
            prev_n_q      <= prev_n_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fault_any_q   <= fault_any_d;
            first_code_q  <= first_code_d;
            first_state_q <= first_state_d;
            overflow_q    <= overflow_d;
            ts_q          <= ts_d;
        end
    end

`ifndef FAULT_LOG_TIMESTAMP_EN
    logic unused_ts;
    assign unused_ts = &{1'b0, iTick_1ms, ts_q, sat_inc16(16'd0)};
`endif

    assign log_if.oLog_Valid = (count_q != 5'd0);
    assign log_if.oLog_Data  = (count_q != 5'd0) ? mem_q[rd_ptr_q] : '0;
    assign oFault_Any        = fault_any_q;
    assign oFirst_Code       = first_code_q;
    assign oFirst_State      = first_state_q;
    assign oOverflow         = overflow_q;
    assign oCount            = count_q;
endmodule
